// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, formats, FSM states.
package inst_encoder_pkg;

  // RV32I major opcodes, identical to the immediate generator / decoder
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // Decoded field bundle presented on the input side
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // True when every bit of the slice is identical (value fits signed range)
  function automatic logic uniform(input logic [20:0] v);
    return (&v) || !(|v);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: decoded fields -> 32-bit RV32I word plus range/opcode error.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] inst,
  output logic        err
);

  fmt_e fmt;
  logic known;
  logic shift;

  // Classify opcode into an encoding format; shifts are I-format with a funct7 field
  always_comb begin
    fmt   = FMT_R;
    known = 1'b1;
    shift = 1'b0;
    case (f.opcode)
      OPC_OP:               fmt = FMT_R;
      OPC_OP_IMM: begin
        fmt   = FMT_I;
        shift = (f.funct3[1:0] == 2'b01);
      end
      OPC_LOAD, OPC_JALR:   fmt = FMT_I;
      OPC_STORE:            fmt = FMT_S;
      OPC_BRANCH:           fmt = FMT_B;
      OPC_JAL:              fmt = FMT_J;
      OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
      default:              known = 1'b0;
    endcase
  end

  // Scatter immediate bits per format; fields a format does not use stay zero
  always_comb begin
    inst = '0;
    err  = 1'b0;
    if (!known) begin
      err = 1'b1;
    end else begin
      case (fmt)
        FMT_R: inst = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
        FMT_I: begin
          if (shift) begin
            inst = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
            err  = |f.imm[31:5];
          end else begin
            inst = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            err  = !uniform(f.imm[31:11]);
          end
        end
        FMT_S: begin
          inst = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
          err  = !uniform(f.imm[31:11]);
        end
        FMT_B: begin
          inst = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                  f.imm[4:1], f.imm[11], f.opcode};
          err  = !uniform({1'b0, f.imm[31:12]} | {f.imm[31], 20'b0}) || f.imm[0];
        end
        FMT_J: begin
          inst = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
          err  = !uniform({{9{f.imm[31]}}, f.imm[31:20]}) || f.imm[0];
        end
        FMT_U: begin
          inst = {f.imm[31:12], f.rd, f.opcode};
          err  = |f.imm[11:0];
        end
        default: begin
          inst = '0;
          err  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder: field bundles in, addressed IMEM words out.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  output logic              done
);

  fields_t           f;
  logic [31:0]       pk_inst;
  logic              pk_err;
  state_e            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic              last_q;
  logic              in_fire, out_fire;

  assign f = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
               funct3: funct3, funct7: funct7, imm: imm};

  inst_pack u_pack (.f(f), .inst(pk_inst), .err(pk_err));

  // Once the final word sits in the output register the stream is closed;
  // otherwise accept whenever the register is empty or draining this cycle.
  assign in_ready = (state == ST_RUN) && !(out_valid && last_q) &&
                    (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state: start opens a stream, handoff of the last word closes it
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start)             state_nx = ST_RUN;
      ST_RUN:  if (out_fire && last_q) state_nx = ST_IDLE;
      default:                        state_nx = ST_IDLE;
    endcase
  end

  // Write-address counter, wraps naturally at 2^ADDR_W
  always_ff @(posedge clk) begin
    if (reset)                          cnt <= '0;
    else if (state == ST_IDLE && start) cnt <= base_addr;
    else if (in_fire)                   cnt <= cnt + ADDR_W'(ADDR_STEP);
  end

  // One-deep output register; holds while stalled downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      inst      <= '0;
      addr      <= '0;
      err       <= 1'b0;
      last_q    <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      inst      <= pk_inst;
      addr      <= cnt;
      err       <= pk_err;
      last_q    <= in_last;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      last_q    <= 1'b0;
    end
  end

  // Single-cycle completion pulse after the final word is taken
  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= out_fire && last_q;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Inverse of the immediate generator: packs decoded instruction fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) into a 32-bit RV32I instruction word. The immediate is scattered into the correct bit positions for each format. Used by the instruction-memory preload path and by test harnesses to stream instructions into IMEM. Valid/ready on both sides, a one-deep output register, a write-address counter and immediate range checking.

Parameters:
ADDR_W, 32, width of the IMEM byte address counter
ADDR_STEP, 4, address increment per accepted output word

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  pulse in IDLE: load base_addr into the counter, enter RUN
base_addr  in  ADDR_W  start address for the stream
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
in_last  in  1  bundle is the final one of the stream
opcode  in  7  RV32I major opcode; same codes as the decoder
rd / rs1 / rs2  in  5 each  register indices
funct3  in  3  funct3
funct7  in  7  funct7; OP and OP_IMM shifts only
imm  in  32  sign-extended immediate value (not pre-shuffled)
out_valid  out  1  encoded word valid
out_ready  in  1  downstream accepts word
inst  out  32  encoded instruction
addr  out  ADDR_W  IMEM address for inst
err  out  1  range or opcode error for this word
done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (synchronous, active-high, overrides all inputs): state=IDLE; out_valid=0, inst=0, addr=0, err=0, done=0; counter=0.
- FSM IDLE: in_ready=0. start=1 -> counter<=base_addr, go to RUN. start in RUN is ignored.
- FSM RUN: in_ready = !out_valid || out_ready. This gives full throughput with no bubble.
- Input handshake (in_valid && in_ready):
  - Register inst, err and addr=counter; set out_valid the next cycle (latency 1).
  - Counter += ADDR_STEP, wrapping modulo 2^ADDR_W.
  - Latch in_last alongside the word.
- Output handshake (out_valid && out_ready) with no new input: out_valid<=0.
- When the last word hands off: done=1 for exactly one cycle, state<=IDLE.
- out_valid=1 && out_ready=0: inst, addr and err hold stable.
- Encodings (R/I/S/B/U/J):
  - OP: funct7, rs2, rs1, funct3, rd; imm is ignored.
  - OP_IMM with funct3 001/101 (shifts): funct7 in [31:25], imm[4:0] in [24:20].
  - Other OP_IMM, JALR, LOAD: I-type, imm[11:0] in [31:20].
  - STORE: imm[11:5] in [31:25], imm[4:0] in [11:7].
  - BRANCH: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7].
  - JAL: imm[20|10:1|11|19:12] in [31:12].
  - LUI/AUIPC: imm[31:12] in [31:12].
  - Fields not used by a format are forced to 0.
- err conditions (the word is still emitted, built from truncated fields):
  - I and S formats: imm[31:11] not all equal.
  - Shift: imm[31:5] != 0.
  - BRANCH: imm[31:12] not all equal, or imm[0]=1.
  - JAL: imm[31:20] not all equal, or imm[0]=1.
  - LUI/AUIPC: imm[11:0] != 0.
  - Unknown opcode: inst=0, err=1.
- Reset asserted mid-stream: the pending word is dropped and done is not pulsed.

Decomposition:
- Shared package holds:
  - The opcode constants, shared with the immediate generator.
  - The format enum R/I/S/B/U/J.
  - The FSM state encoding.
- Sub-module inst_pack: purely combinational fields -> {inst, err}. The top level holds the FSM, counter and handshake register.

Test Plan:
- start, base_addr=0x100; addi x1,x0,5 (OP_IMM, rd=1, imm=5) -> inst=0x00500093, addr=0x100, err=0.
- lui x5, imm=0x12345000 -> 0x123452B7; beq x1,x2, imm=-4 -> 0xFE208EE3; jal x1, imm=2048 -> 0x001000EF. Checks the B/J scrambling.
- addi imm=2048; beq imm=3; lui imm=0x12345001 -> err=1 on each; unknown opcode 0x7F -> inst=0, err=1.
- Stream of 4 words with out_ready held low for 3 cycles on word 2:
  - inst and addr hold stable and in_ready=0.
  - Addresses 0x100, 0x104, 0x108, 0x10C.
  - done pulses once after word 4, then in_ready=0.
- ADDR_W=8, base_addr=0xFC, 2 words -> addr 0xFC then 0x00 (wrap).
- reset asserted while out_valid=1 -> next cycle out_valid=0, state IDLE, done=0; a fresh start restarts cleanly.
